// File: rtl/prefetch_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prefetch_loader_if
// Purpose  : Job request, memory read port and buffer fill signals of the
//            prefetch loader, bundled for connection between blocks.
// Revision : 1.0 - initial release
// ============================================================================
interface prefetch_loader_if;
    // Job request / status
    logic        start;
    logic [31:0] start_address;
    logic [31:0] length;
    logic        busy;
    logic        done;
    logic        overflow;

    // Memory read port
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;

    // Prefetch buffer fill side
    logic        wait_prefetch_enable;
    logic        prefetch_enable;
    logic        prefetch_finish;
    logic [31:0] buf_start_address;
    logic [31:0] buf_length;
    logic        buf_write;
    logic [31:0] buf_addr;
    logic [63:0] buf_data;

    // Loader side
    modport master (
        input  start, start_address, length,
        output busy, done, overflow,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output wait_prefetch_enable, prefetch_enable, prefetch_finish,
        output buf_start_address, buf_length, buf_write, buf_addr, buf_data
    );

    // Environment side (job source, memory and buffer)
    modport slave (
        output start, start_address, length,
        input  busy, done, overflow,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  wait_prefetch_enable, prefetch_enable, prefetch_finish,
        input  buf_start_address, buf_length, buf_write, buf_addr, buf_data
    );
endinterface
`default_nettype wire

// File: rtl/prefetch_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prefetch_loader
// Purpose  : Fill-side engine of a prefetch buffer. Arms and enables the
//            buffer, issues single-beat 64-bit memory reads with a bounded
//            number in flight, writes each returning beat at its index and
//            signals completion.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_loader #(
    parameter int DEPTH           = 4096,
    parameter int MAX_OUTSTANDING = 8
) (
    input wire                clk,
    input wire                rst,
    prefetch_loader_if.master bus
);

    // Beat counters need one extra bit so that a full-DEPTH job is representable
    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [3:0]    C_MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_ENABLE = 3'd2,
        S_FETCH  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Control state
    state_t        state_q, state_d;
    logic [CW-1:0] nbeats_q;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] received_q, received_d;
    logic [3:0]    outstanding_q, outstanding_d;

    // Latched job
    logic [31:0]   base_q;
    logic [31:0]   start_addr_q;
    logic [31:0]   length_q;
    logic          overflow_q;

    // Registered outputs
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          req_valid_q, req_valid_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          wait_en_q, wait_en_d;
    logic          pf_en_q, pf_en_d;
    logic          pf_fin_q, pf_fin_d;
    logic          buf_write_q, buf_write_d;
    logic [31:0]   buf_addr_q, buf_addr_d;
    logic [63:0]   buf_data_q, buf_data_d;

    // Job decode and handshake qualifiers
    logic [29:0]   job_beats;
    logic          job_clamp;
    logic [CW-1:0] job_nbeats;
    logic          start_take;
    logic          req_accept;
    logic          rsp_take;

    // Beat count of the job on the start inputs; 33-bit sum so a byte count
    // near 4 GiB cannot wrap to a short job
    always_comb begin
        job_beats  = 30'(({30'd0, bus.start_address[2:0]} + {1'b0, bus.length} + 33'd7) >> 3);
        job_clamp  = (job_beats > 30'(DEPTH));
        job_nbeats = job_clamp ? C_DEPTH : CW'(job_beats);
    end

    assign start_take = (state_q == S_IDLE) && bus.start;
    assign req_accept = req_valid_q && bus.mem_req_ready;
    // A response with nothing outstanding is a leftover from before a reset
    assign rsp_take   = bus.mem_rsp_valid && (outstanding_q != 4'd0);

    // Next state and counter updates
    always_comb begin
        state_d       = state_q;
        issued_d      = issued_q;
        received_d    = received_q;
        outstanding_d = outstanding_q;

        if (req_accept) begin
            issued_d = issued_q + CW'(1);
        end
        if (rsp_take) begin
            received_d = received_q + CW'(1);
        end
        case ({req_accept, rsp_take})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d       = S_ARM;
                    issued_d      = '0;
                    received_d    = '0;
                    outstanding_d = '0;
                end
            end
            S_ARM:    state_d = S_ENABLE;
            S_ENABLE: state_d = (nbeats_q == '0) ? S_FINISH : S_FETCH;
            // received reaches nbeats in the cycle the last write is driven
            S_FETCH: begin
                if (received_q == nbeats_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so every
    // output leaves a flop
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
        wait_en_d   = (state_d == S_ARM);
        pf_en_d     = (state_d == S_ENABLE);
        pf_fin_d    = (state_d == S_FINISH);
        // issued only moves on an accept, so a stalled request holds its address
        req_valid_d = (state_d == S_FETCH) && (issued_d < nbeats_q) &&
                      (outstanding_d < C_MAX_OUT);
        req_addr_d  = base_q + (32'(issued_d) << 3);
        buf_write_d = rsp_take;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (rsp_take) begin
            buf_addr_d = 32'(received_q[AW-1:0]);
            buf_data_d = bus.mem_rsp_data;
        end
    end

    // State register, counters and job latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            nbeats_q      <= '0;
            base_q        <= '0;
            start_addr_q  <= '0;
            length_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
            if (start_take) begin
                start_addr_q <= bus.start_address;
                length_q     <= bus.length;
                base_q       <= {bus.start_address[31:3], 3'b000};
                nbeats_q     <= job_nbeats;
                overflow_q   <= job_clamp;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            wait_en_q   <= 1'b0;
            pf_en_q     <= 1'b0;
            pf_fin_q    <= 1'b0;
            buf_write_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            wait_en_q   <= wait_en_d;
            pf_en_q     <= pf_en_d;
            pf_fin_q    <= pf_fin_d;
            buf_write_q <= buf_write_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.overflow             = overflow_q;
    assign bus.mem_req_valid        = req_valid_q;
    assign bus.mem_req_addr         = req_addr_q;
    assign bus.wait_prefetch_enable = wait_en_q;
    assign bus.prefetch_enable      = pf_en_q;
    assign bus.prefetch_finish      = pf_fin_q;
    assign bus.buf_start_address    = start_addr_q;
    assign bus.buf_length           = length_q;
    assign bus.buf_write            = buf_write_q;
    assign bus.buf_addr             = buf_addr_q;
    assign bus.buf_data             = buf_data_q;

endmodule
`default_nettype wire
